// File: rtl/ps2_send.sv
// rtl/ps2_send.sv - PS/2 host-to-device command transmitter with open-drain line enables
module ps2_send #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int FW   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_RELEASE
    } state_t;

    logic          clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
    logic          filt_q;
    logic [FW-1:0] fcnt_q;
    logic          fall_w;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [9:0]    shift_q;
    logic [3:0]    bitcnt_q;
    logic          clk_oe_q, data_oe_q, busy_q, done_q, err_q;
    logic          timeout_w;

    // Filtered level flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
            filt_q    <= 1'b1;
            fcnt_q    <= '0;
        end else begin
            clk_s1_q  <= ps2_clk;
            clk_s2_q  <= clk_s1_q;
            data_s1_q <= ps2_data;
            data_s2_q <= data_s1_q;
            if (clk_s2_q == filt_q) begin
                fcnt_q <= '0;
            end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_q <= clk_s2_q;
                fcnt_q <= '0;
            end else begin
                fcnt_q <= fcnt_q + 1'b1;
            end
        end
    end

    // Fall is flagged on the same edge the filter commits to the new low level.
    assign fall_w    = filt_q & ~clk_s2_q & (fcnt_q == FW'(FILTER_LEN - 1));
    assign timeout_w = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            bitcnt_q  <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    if (start && !done_q) begin
                        shift_q  <= {1'b1, ~^tx_data, tx_data};
                        err_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        clk_oe_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
                        data_oe_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= S_REQ;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_REQ: begin
                    clk_oe_q <= 1'b0;
                    cnt_q    <= '0;
                    bitcnt_q <= '0;
                    state_q  <= S_SEND;
                end
                S_SEND: begin
                    if (fall_w) begin
                        data_oe_q <= ~shift_q[0];
                        shift_q   <= {1'b0, shift_q[9:1]};
                        bitcnt_q  <= bitcnt_q + 1'b1;
                        cnt_q     <= '0;
                        if (bitcnt_q == 4'd9) begin
                            state_q <= S_ACK;
                        end
                    end else if (timeout_w) begin
                        err_q     <= 1'b1;
                        data_oe_q <= 1'b0;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_ACK: begin
                    if (fall_w) begin
                        err_q   <= data_s2_q;
                        cnt_q   <= '0;
                        state_q <= S_RELEASE;
                    end else if (timeout_w) begin
                        err_q     <= 1'b1;
                        data_oe_q <= 1'b0;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (filt_q && data_s2_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (timeout_w) begin
                        err_q     <= 1'b1;
                        data_oe_q <= 1'b0;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ps2_send.sv
// tb/tb_ps2_send.sv - directed and random PS/2 host-to-device transfers against a device model
module tb_ps2_send;

    localparam int INH = 40;
    localparam int TO  = 1500;
    localparam int FL  = 8;
    localparam int H   = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       ps2_clk_oe, ps2_data_oe, busy, done, err;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_w, ps2_data_w;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int viol = 0;
    logic mon_en = 1'b0;
    logic prev_doe = 1'b0;
    logic prev_coe = 1'b0;
    int inh_cnt, ovl_cnt, req_exit_cyc;

    assign ps2_clk_w  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_w = ~(ps2_data_oe | dev_data_low);

    ps2_send #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
        .clk(clk), .reset(rst_n), .ps2_clk(ps2_clk_w), .ps2_data(ps2_data_w),
        .start(start), .tx_data(tx_data), .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Host data may only move while the device holds the clock low, shortly after its fall.
    always @(negedge clk) begin
        if (mon_en && (ps2_data_oe !== prev_doe) && !ps2_clk_oe && !prev_coe) begin
            if ((cyc - fall_cyc > 3 + FL) || !dev_clk_low) viol <= viol + 1;
        end
        prev_doe <= ps2_data_oe;
        prev_coe <= ps2_clk_oe;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic [10:0] f;
        f = '0;
        for (int i = 0; i < 11; i++) begin
            if (i == 0)       f[i] = 1'b0;
            else if (i <= 8)  f[i] = ((b >> (i - 1)) & 8'd1) != 0;
            else if (i == 9)  f[i] = ($countones(b) % 2) == 0;
            else              f[i] = 1'b1;
        end
        return f;
    endfunction

    task automatic do_start(input logic [7:0] b);
        tx_data = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        tx_data = ~b;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    // Device side: waits for the request, clocks the frame in, optionally ACKs, waits for done.
    task automatic xfer(input int ack_low, input int stop_fall, input int poke_fall,
                        input int poke_done, output logic [10:0] frame,
                        output logic d_err, output logic d_busy, output int got_done);
        int n;
        frame = '0; d_err = 1'bx; d_busy = 1'bx; got_done = 0;
        inh_cnt = 0; ovl_cnt = 0; n = 0;
        while (!(ps2_clk_oe == 1'b0 && (inh_cnt + ovl_cnt) > 0) && n < 20000) begin
            if (ps2_clk_oe && !ps2_data_oe) inh_cnt++;
            if (ps2_clk_oe && ps2_data_oe) ovl_cnt++;
            tick();
            n++;
        end
        req_exit_cyc = cyc;
        if (stop_fall == 0) return;
        wait_n(H);
        frame[0] = ps2_data_w;
        for (int k = 1; k <= 10; k++) begin
            dev_clk_low = 1'b1;
            fall_cyc = cyc;
            if (k == poke_fall) begin
                tx_data = 8'h55; start = 1'b1; tick(); start = 1'b0;
                wait_n(H - 1);
            end else begin
                wait_n(H);
            end
            if (k == stop_fall) return;
            frame[k] = ps2_data_w;
            dev_clk_low = 1'b0;
            wait_n(H);
        end
        if (ack_low != 0) dev_data_low = 1'b1;
        wait_n(H / 2);
        dev_clk_low = 1'b1;
        fall_cyc = cyc;
        wait_n(H);
        dev_clk_low = 1'b0;
        wait_n(2);
        dev_data_low = 1'b0;
        n = 0;
        while (n < 5000 && got_done == 0) begin
            if (done) begin
                got_done = 1; d_err = err; d_busy = busy;
            end else begin
                tick();
                n++;
            end
        end
        if (poke_done != 0 && got_done != 0) begin
            tx_data = 8'h55; start = 1'b1; tick(); start = 1'b0;
        end
    endtask

    initial begin
        logic [10:0] fr;
        logic        e, bz;
        int          gd, n, done_cyc;
        logic [7:0]  rb;

        wait_n(4);
        chk("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        chk("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        wait_n(20);

        do_start(8'hED);
        xfer(1, 99, 0, 0, fr, e, bz, gd);
        chk("ed_inhibit_len", inh_cnt, INH);
        chk("ed_req_len", ovl_cnt, 1);
        chk("ed_frame", {21'd0, fr}, {21'd0, exp_frame(8'hED)});
        chk("ed_done", gd, 1);
        chk("ed_err", {31'd0, e}, 32'd0);
        chk("ed_busy_at_done", {31'd0, bz}, 32'd0);
        tick();
        chk("ed_busy_after", {31'd0, busy}, 32'd0);
        chk("ed_lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        wait_n(10);

        viol = 0;
        do_start(8'h02);
        mon_en = 1'b1;
        xfer(1, 99, 0, 0, fr, e, bz, gd);
        mon_en = 1'b0;
        chk("02_frame", {21'd0, fr}, {21'd0, exp_frame(8'h02)});
        chk("02_parity", {31'd0, fr[9]}, 32'd0);
        chk("02_err", {31'd0, e}, 32'd0);
        chk("02_data_timing", viol, 0);
        wait_n(10);

        do_start(8'hF4);
        xfer(1, 0, 0, 0, fr, e, bz, gd);
        n = 0;
        while (!done && n < TO + 200) begin tick(); n++; end
        done_cyc = cyc;
        chk("to_done_seen", {31'd0, done}, 32'd1);
        chk("to_latency", done_cyc - req_exit_cyc, TO);
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        wait_n(10);

        do_start(8'h3C);
        xfer(0, 99, 0, 0, fr, e, bz, gd);
        chk("noack_done", gd, 1);
        chk("noack_err", {31'd0, e}, 32'd1);
        wait_n(10);
        do_start(8'hF4);
        chk("f4_err_cleared", {31'd0, err}, 32'd0);
        xfer(1, 99, 0, 0, fr, e, bz, gd);
        chk("f4_frame", {21'd0, fr}, {21'd0, exp_frame(8'hF4)});
        chk("f4_err", {31'd0, e}, 32'd0);
        wait_n(10);

        do_start(8'hA7);
        xfer(1, 4, 0, 0, fr, e, bz, gd);
        rst_n = 1'b0;
        tick();
        chk("midrst_outputs", {27'd0, ps2_clk_oe, ps2_data_oe, busy, done, err}, 32'd0);
        dev_clk_low = 1'b0;
        rst_n = 1'b1;
        wait_n(30);
        do_start(8'hFF);
        xfer(1, 99, 0, 0, fr, e, bz, gd);
        chk("ff_frame", {21'd0, fr}, {21'd0, exp_frame(8'hFF)});
        chk("ff_parity", {31'd0, fr[9]}, 32'd1);
        chk("ff_err", {31'd0, e}, 32'd0);
        wait_n(10);

        do_start(8'hA3);
        xfer(1, 99, 3, 1, fr, e, bz, gd);
        chk("poke_frame", {21'd0, fr}, {21'd0, exp_frame(8'hA3)});
        chk("poke_err", {31'd0, e}, 32'd0);
        wait_n(3);
        chk("poke_done_ignored", {30'd0, busy, ps2_clk_oe}, 32'd0);
        wait_n(10);

        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom_range(0, 255));
            do_start(rb);
            xfer(1, 99, 0, 0, fr, e, bz, gd);
            chk("rand_frame", {21'd0, fr}, {21'd0, exp_frame(rb)});
            chk("rand_err", {31'd0, e}, 32'd0);
            wait_n(10);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
